// File: rtl/tsbus_arbiter.sv
// Round-robin arbiter sharing one tristate bus among four inverting buffer drivers.
// Registered active-low grants with a programmable break-before-make dead time and an optional hold limit.
module tsbus_arbiter #(
    parameter int unsigned DEAD    = 2,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic       clk,
    input  logic       clr_,
    input  logic [3:0] req_,
    output logic [3:0] gnt_,
    output logic       busy,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    localparam logic [3:0] DEAD_LAST = 4'(DEAD - 1);
    localparam logic       HOLD_EN   = (MAXHOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAXHOLD != 0) ? 8'(MAXHOLD - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] dead_q, dead_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       any_req;
    logic       others_req;
    logic       start_grant;
    logic       end_grant;

    // First active request scanning upward from ptr with wrap.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && !req_[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req    = ~&req_;
    assign others_req = |(~req_ & ~(4'b0001 << owner_q));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        dead_d      = dead_q;
        start_grant = 1'b0;
        end_grant   = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    start_grant = 1'b1;
                end
            end
            GRANT: begin
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                if (req_[owner_q] || (HOLD_EN && (hold_q >= HOLD_LAST) && others_req)) begin
                    end_grant = 1'b1;
                end
            end
            TURN: begin
                if (dead_q == DEAD_LAST) begin
                    if (any_req) begin
                        start_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    dead_d = dead_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_grant) begin
            state_d = GRANT;
            gnt_d   = ~(4'b0001 << win);
            owner_d = win;
            busy_d  = 1'b1;
            hold_d  = '0;
        end
        if (end_grant) begin
            state_d = TURN;
            gnt_d   = '1;
            busy_d  = 1'b0;
            ptr_d   = owner_q + 2'd1;
            dead_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state_q <= IDLE;
            gnt_q   <= '1;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            dead_q  <= dead_d;
        end
    end

    assign gnt_  = gnt_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_tsbus_arbiter.sv
// Directed bench for tsbus_arbiter: one unlimited-hold instance (a) and one MAXHOLD=4 instance (b).
module tb_tsbus_arbiter;

    logic       clk;
    logic       clr_;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic       busy_a, busy_b;
    logic [1:0] owner_a, owner_b;

    int n_checks = 0;
    int n_errors = 0;

    tsbus_arbiter #(.DEAD(2), .MAXHOLD(0)) dut_a (
        .clk   (clk),
        .clr_  (clr_),
        .req_  (req_a),
        .gnt_  (gnt_a),
        .busy  (busy_a),
        .owner (owner_a)
    );

    tsbus_arbiter #(.DEAD(2), .MAXHOLD(4)) dut_b (
        .clk   (clk),
        .clr_  (clr_),
        .req_  (req_b),
        .gnt_  (gnt_b),
        .busy  (busy_b),
        .owner (owner_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Contention and break-before-make monitor, sampled mid-cycle.
    logic [3:0] prev_a = 4'hF, prev_b = 4'hF;
    int         gap_a = 99, gap_b = 99;

    always @(negedge clk) begin
        check("onehot_a", 32'($countones(~gnt_a) <= 1), 32'd1);
        check("onehot_b", 32'($countones(~gnt_b) <= 1), 32'd1);
        if (!clr_) begin
            gap_a = 99;
            gap_b = 99;
        end else begin
            if (prev_a == 4'hF && gnt_a != 4'hF) check("gap_a", 32'(gap_a >= 2), 32'd1);
            if (prev_b == 4'hF && gnt_b != 4'hF) check("gap_b", 32'(gap_b >= 2), 32'd1);
            gap_a = (gnt_a == 4'hF) ? gap_a + 1 : 0;
            gap_b = (gnt_b == 4'hF) ? gap_b + 1 : 0;
        end
        prev_a = gnt_a;
        prev_b = gnt_b;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_  = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b1111;

        // Reset with all requests active
        cyc(2);
        check("rst_gnt", 32'(gnt_a), 32'hE ^ 32'h1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_owner", 32'(owner_a), 32'd0);
        clr_ = 1'b1;
        cyc(1);
        check("first_gnt", 32'(gnt_a), 32'hE);
        check("first_owner", 32'(owner_a), 32'd0);
        check("first_busy", 32'(busy_a), 32'd1);
        req_a = 4'b1111;
        cyc(1);
        check("rel_gnt", 32'(gnt_a), 32'hF);
        check("rel_busy", 32'(busy_a), 32'd0);
        cyc(2);
        check("idle_gnt", 32'(gnt_a), 32'hF);

        // Single requester on driver 2
        req_a = 4'b1011;
        cyc(1);
        check("single_gnt", 32'(gnt_a), 32'hB);
        check("single_owner", 32'(owner_a), 32'd2);
        check("single_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("single_hold", 32'(gnt_a), 32'hB);
        end
        req_a = 4'b1111;
        cyc(1);
        check("single_rel", 32'(gnt_a), 32'hF);
        check("single_rel_busy", 32'(busy_a), 32'd0);
        check("turn_owner", 32'(owner_a), 32'd2);
        cyc(1);
        check("single_dead1", 32'(gnt_a), 32'hF);
        cyc(1);
        check("single_idle", 32'(gnt_a), 32'hF);
        req_a = 4'b1110;
        cyc(1);
        check("idle_regrant", 32'(gnt_a), 32'hE);
        check("idle_regrant_own", 32'(owner_a), 32'd0);
        req_a = 4'b1111;
        cyc(3);

        // Round robin from a fresh reset, all drivers requesting
        clr_ = 1'b0;
        cyc(1);
        check("rst2_gnt", 32'(gnt_a), 32'hF);
        clr_  = 1'b1;
        req_a = 4'b0000;
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            check("rr_gnt", 32'(gnt_a), 32'(4'hF & ~(4'b0001 << k)));
            check("rr_owner", 32'(owner_a), 32'(k));
            cyc(1);
            check("rr_gnt2", 32'(gnt_a), 32'(4'hF & ~(4'b0001 << k)));
            cyc(1);
            check("rr_gnt3", 32'(gnt_a), 32'(4'hF & ~(4'b0001 << k)));
            req_a[k] = 1'b1;
            cyc(1);
            check("rr_dead0", 32'(gnt_a), 32'hF);
            req_a[k] = 1'b0;
            cyc(1);
            check("rr_dead1", 32'(gnt_a), 32'hF);
            check("rr_dead_owner", 32'(owner_a), 32'(k));
            cyc(1);
        end
        check("rr_wrap_gnt", 32'(gnt_a), 32'hE);
        check("rr_wrap_owner", 32'(owner_a), 32'd0);

        // Get driver 1 granted, then assert reset between edges
        req_a = 4'b1101;
        cyc(1);
        check("pre_rst_d0", 32'(gnt_a), 32'hF);
        cyc(1);
        check("pre_rst_d1", 32'(gnt_a), 32'hF);
        cyc(1);
        check("pre_rst_gnt", 32'(gnt_a), 32'hD);
        #3;
        clr_ = 1'b0;
        #1;
        check("async_gnt", 32'(gnt_a), 32'hF);
        check("async_busy", 32'(busy_a), 32'd0);
        check("async_owner", 32'(owner_a), 32'd0);
        @(posedge clk);
        #1;
        req_a = 4'b0000;
        clr_  = 1'b1;
        cyc(1);
        check("post_rst_gnt", 32'(gnt_a), 32'hE);
        check("post_rst_owner", 32'(owner_a), 32'd0);
        req_a = 4'b1111;
        cyc(3);

        // Hold-limit preemption on instance b
        req_b = 4'b1110;
        cyc(1);
        check("pre_s1", 32'(gnt_b), 32'hE);
        cyc(1);
        check("pre_s2", 32'(gnt_b), 32'hE);
        req_b = 4'b1010;
        cyc(1);
        check("pre_s3", 32'(gnt_b), 32'hE);
        cyc(1);
        check("pre_s4", 32'(gnt_b), 32'hE);
        cyc(1);
        check("pre_dead0", 32'(gnt_b), 32'hF);
        check("pre_dead_busy", 32'(busy_b), 32'd0);
        cyc(1);
        check("pre_dead1", 32'(gnt_b), 32'hF);
        cyc(1);
        check("pre_next_gnt", 32'(gnt_b), 32'hB);
        check("pre_next_owner", 32'(owner_b), 32'd2);
        req_b = 4'b1110;
        cyc(1);
        check("back_dead0", 32'(gnt_b), 32'hF);
        cyc(1);
        check("back_dead1", 32'(gnt_b), 32'hF);
        cyc(1);
        check("back_gnt", 32'(gnt_b), 32'hE);
        check("back_owner", 32'(owner_b), 32'd0);
        for (int i = 0; i < 45; i++) begin
            cyc(1);
            check("long_hold", 32'(gnt_b), 32'hE);
        end
        req_b = 4'b1111;
        cyc(3);
        check("end_gnt_b", 32'(gnt_b), 32'hF);
        check("end_busy_b", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
